cache_controller: RTL

Direct-mapped cache controller that sits directly upstream of the cache data array. It accepts word-sized CPU requests over a valid/ready handshake, keeps its own tag and valid array, and drives the data array's select/write/index/offset/mem_write/mem_read port. It refills a full line from main memory on a read miss and forwards every write to memory (write-through, no-write-allocate).

---
 rtl/cache_controller_pkg.sv | 42 ++++
 rtl/cache_controller_tag_array.sv | 45 ++++
 rtl/cache_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cache_controller_pkg.sv
// memory_sub_system_param
// Shared geometry, state type and address helpers for the memory sub-system.
// Addresses are word addresses split as {tag, index, offset}; a cache line
// holds 2**OFFSET_LENGTH words, with word k at bits [k*WORD_SIZE +: WORD_SIZE].
package memory_sub_system_param;

  localparam int WORD_SIZE       = 32;
  localparam int OFFSET_LENGTH   = 2;
  localparam int INDEX_LENGTH    = 3;
  localparam int TAG_LENGTH      = 11;
  localparam int ADDR_LENGTH     = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;
  localparam int WORDS_PER_LINE  = 1 << OFFSET_LENGTH;
  localparam int CACHE_LINE_SIZE = WORD_SIZE * WORDS_PER_LINE;
  localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL,
    WR_MEM,
    RESP
  } cache_state_t;

  function automatic logic [TAG_LENGTH-1:0] addr_tag(input logic [ADDR_LENGTH-1:0] a);
    return a[ADDR_LENGTH-1 -: TAG_LENGTH];
  endfunction

  function automatic logic [INDEX_LENGTH-1:0] addr_index(input logic [ADDR_LENGTH-1:0] a);
    return a[OFFSET_LENGTH +: INDEX_LENGTH];
  endfunction

  function automatic logic [OFFSET_LENGTH-1:0] addr_offset(input logic [ADDR_LENGTH-1:0] a);
    return a[OFFSET_LENGTH-1:0];
  endfunction

  function automatic logic [WORD_SIZE-1:0] line_word(input logic [CACHE_LINE_SIZE-1:0] line,
                                                     input logic [OFFSET_LENGTH-1:0]   off);
    return line[int'(off)*WORD_SIZE +: WORD_SIZE];
  endfunction

endpackage

// File: rtl/cache_controller_tag_array.sv
// cache_tag_array
// Valid bit + tag per cache line. Asynchronous read, synchronous write,
// valid bits cleared asynchronously by resetn (tags are left as-is).
// Ports:
//   clk, resetn          clock / async active-low reset
//   rd_index             line to look up
//   rd_valid, rd_tag     contents of that line (combinational)
//   wr_en, wr_index      install wr_tag at wr_index and mark it valid
//   wr_tag
module cache_tag_array
  import memory_sub_system_param::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INDEX_LENGTH-1:0] rd_index,
  output logic                    rd_valid,
  output logic [TAG_LENGTH-1:0]   rd_tag,
  input  logic                    wr_en,
  input  logic [INDEX_LENGTH-1:0] wr_index,
  input  logic [TAG_LENGTH-1:0]   wr_tag
);

  logic [NUM_CACHE_LINES-1:0] valid_bits;
  logic [TAG_LENGTH-1:0]      tags [NUM_CACHE_LINES];

  // Valid bits are the only state that must be clean after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Tag storage needs no reset: a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tags[rd_index];

endmodule

// File: rtl/cache_controller.sv
// cache_controller
// Direct-mapped, write-through, no-write-allocate cache controller that drives
// an external data array and talks to main memory.
// Ports:
//   clk, resetn                          clock / async active-low reset
//   cpu_req_valid/ready, cpu_req_write,  CPU request handshake and payload
//   cpu_addr, cpu_wdata
//   cpu_resp_valid, cpu_rdata            one-cycle response (rdata 0 for writes)
//   mem_rd_req/addr/valid/line           line refill from main memory
//   mem_wr_req/addr/data/ack             word write-through to main memory
//   select, write, index, offset,        data array update port
//   mem_write, mem_read
//   dout                                 data array line read at index
module cache_controller
  import memory_sub_system_param::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic                       cpu_req_write,
  input  logic [ADDR_LENGTH-1:0]     cpu_addr,
  input  logic [WORD_SIZE-1:0]       cpu_wdata,
  output logic                       cpu_resp_valid,
  output logic [WORD_SIZE-1:0]       cpu_rdata,
  output logic                       mem_rd_req,
  output logic [ADDR_LENGTH-1:0]     mem_rd_addr,
  input  logic                       mem_rd_valid,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rd_line,
  output logic                       mem_wr_req,
  output logic [ADDR_LENGTH-1:0]     mem_wr_addr,
  output logic [WORD_SIZE-1:0]       mem_wr_data,
  input  logic                       mem_wr_ack,
  output logic                       select,
  output logic                       write,
  output logic [INDEX_LENGTH-1:0]    index,
  output logic [OFFSET_LENGTH-1:0]   offset,
  output logic [WORD_SIZE-1:0]       mem_write,
  output logic [CACHE_LINE_SIZE-1:0] mem_read,
  input  logic [CACHE_LINE_SIZE-1:0] dout
);

  cache_state_t             state;
  logic                     req_write;
  logic [ADDR_LENGTH-1:0]   req_addr;
  logic [WORD_SIZE-1:0]     req_wdata;
  logic                     req_hit;
  logic                     tag_valid;
  logic [TAG_LENGTH-1:0]    tag_q;
  logic                     hit_now;

  // The tag array is probed with the incoming address so the hit result is
  // ready at acceptance; this lets a write hit present its registered data
  // array update during LOOKUP. Tags only change in FILL, so the result is
  // still accurate one cycle later.
  cache_tag_array u_tag_array (
    .clk      (clk),
    .resetn   (resetn),
    .rd_index (addr_index(cpu_addr)),
    .rd_valid (tag_valid),
    .rd_tag   (tag_q),
    .wr_en    (state == FILL),
    .wr_index (index),
    .wr_tag   (addr_tag(req_addr))
  );

  assign hit_now = tag_valid && (tag_q == addr_tag(cpu_addr));

  // Main FSM; every output is a flop set on the transition into the state
  // in which it must be visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_rd_req     <= 1'b0;
      mem_rd_addr    <= '0;
      mem_wr_req     <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      select         <= 1'b0;
      write          <= 1'b0;
      index          <= '0;
      offset         <= '0;
      mem_write      <= '0;
      mem_read       <= '0;
      req_write      <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_hit        <= 1'b0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cpu_req_ready <= 1'b1;
          if (cpu_req_valid && cpu_req_ready) begin
            cpu_req_ready <= 1'b0;
            req_write     <= cpu_req_write;
            req_addr      <= cpu_addr;
            req_wdata     <= cpu_wdata;
            req_hit       <= hit_now;
            index         <= addr_index(cpu_addr);
            offset        <= addr_offset(cpu_addr);
            if (cpu_req_write && hit_now) begin
              write     <= 1'b1;
              select    <= 1'b1;
              mem_write <= cpu_wdata;
            end
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          write <= 1'b0;
          if (req_write) begin
            mem_wr_req  <= 1'b1;
            mem_wr_addr <= req_addr;
            mem_wr_data <= req_wdata;
            state       <= WR_MEM;
          end else if (req_hit) begin
            cpu_rdata      <= line_word(dout, offset);
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= {req_addr[ADDR_LENGTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
            state       <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_rd_valid) begin
            mem_rd_req <= 1'b0;
            mem_read   <= mem_rd_line;
            select     <= 1'b0;
            write      <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          write          <= 1'b0;
          cpu_rdata      <= line_word(mem_read, offset);
          cpu_resp_valid <= 1'b1;
          state          <= RESP;
        end
        WR_MEM: begin
          if (mem_wr_ack) begin
            mem_wr_req     <= 1'b0;
            cpu_rdata      <= '0;
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
